// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the multiplier arbiter.
package mult_arb_pkg;

  localparam int unsigned OPW = 8;
  localparam int unsigned PW  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping N-1 -> 0.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  // Scan requesters in priority order starting at the pointer; keep the first hit.
  always_comb begin
    int unsigned k;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr_i) + i) % N;
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sequencer sharing one sequential Booth multiplier among N requesters.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [OPW*N-1:0] req_a,
  input  logic [OPW*N-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [IDW-1:0]   resp_id,
  output logic [PW-1:0]    resp_data,
  output logic             mul_start,
  output logic [OPW-1:0]   mul_a,
  output logic [OPW-1:0]   mul_b,
  input  logic [PW-1:0]    mul_out,
  input  logic             mul_busy
);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [OPW-1:0] a_q, a_d;
  logic [OPW-1:0] b_q, b_d;
  logic [PW-1:0]  data_q, data_d;

  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic           hs;
  logic [IDW-1:0] ptr_nxt;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // A stale multiplier run (it has no reset) blocks any new grant until it finishes.
  assign hs      = (state_q == ST_IDLE) && gnt_any && !mul_busy;
  assign ptr_nxt = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + IDW'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: pointer, captured operands, tag and product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      id_q   <= id_d;
      a_q    <= a_d;
      b_q    <= b_d;
      data_q <= data_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hs) begin
          state_d = ST_LAUNCH;
          ptr_d   = ptr_nxt;
          id_d    = gnt_idx;
          a_d     = req_a[OPW*32'(gnt_idx) +: OPW];
          b_d     = req_b[OPW*32'(gnt_idx) +: OPW];
        end
      end
      ST_LAUNCH:    state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (mul_busy) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (!mul_busy) begin
          data_d  = mul_out;
          state_d = ST_RESP;
        end
      end
      ST_RESP:      if (resp_ready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; grant gated by idle and multiplier idle.
  always_comb begin
    req_ready  = '0;
    mul_start  = 1'b0;
    resp_valid = 1'b0;
    if (state_q == ST_IDLE && !mul_busy) req_ready = gnt;
    if (state_q == ST_LAUNCH)            mul_start = 1'b1;
    if (state_q == ST_RESP)              resp_valid = 1'b1;
  end

  assign resp_id   = id_q;
  assign resp_data = data_q;
  assign mul_a     = a_q;
  assign mul_b     = b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural 8-cycle multiplier.
module tb_mult_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [8*N-1:0]   req_a = '0;
  logic [8*N-1:0]   req_b = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic [IDW-1:0]   resp_id;
  logic [15:0]      resp_data;
  logic             mul_start;
  logic [7:0]       mul_a, mul_b;
  logic [15:0]      mul_out = 16'h0000;
  logic             mul_busy = 1'b0;

  int          mcnt = 0;
  logic [15:0] mprod = 16'h0000;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  // Behavioural model state
  bit          m_out = 0;
  int          m_hs = 0;
  int          m_id = 0;
  int          m_ptr = 0;
  logic [7:0]  m_a, m_b;
  logic [15:0] m_p;

  // Observed transaction log
  int          hs_id_q[$];
  int          hs_cyc_q[$];
  int          rsp_cyc_q[$];
  int          rsp_id_q[$];
  logic [15:0] rsp_dat_q[$];

  mult_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_out    (mul_out),
    .mul_busy   (mul_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    return 16'(sa * sb);
  endfunction

  // Multiplier stand-in: busy for 8 cycles after start, output garbage until done, no reset.
  always @(posedge clk) begin
    if (mul_start && !mul_busy) begin
      mul_busy <= 1'b1;
      mcnt     <= 8;
      mprod    <= smul(mul_a, mul_b);
      mul_out  <= 16'hDEAD;
    end else if (mul_busy) begin
      if (mcnt == 1) begin
        mul_busy <= 1'b0;
        mul_out  <= mprod;
      end
      mcnt <= mcnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level reference model and per-cycle compare.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    bit           exp_rv;
    int           k;
    int           j;
    bit           seen;
    if (rst) begin
      m_out = 0;
      m_ptr = 0;
      chk("m_rst_resp_valid", 32'(resp_valid), 0);
      chk("m_rst_resp_data", 32'(resp_data), 0);
      chk("m_rst_resp_id", 32'(resp_id), 0);
      chk("m_rst_mul_start", 32'(mul_start), 0);
      chk("m_rst_mul_a", 32'(mul_a), 0);
      chk("m_rst_mul_b", 32'(mul_b), 0);
    end else begin
      exp_rdy = '0;
      k = -1;
      if (!m_out && !mul_busy) begin
        for (int i = 0; i < N; i++) begin
          j = (m_ptr + i) % N;
          if (k < 0 && req_valid[j]) k = j;
        end
      end
      if (k >= 0) exp_rdy[k] = 1'b1;
      chk("m_req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("m_mul_start", 32'(mul_start), 32'(m_out && (cyc == m_hs + 1)));
      if (m_out && cyc >= m_hs + 1 && cyc <= m_hs + 10) begin
        chk("m_mul_a", 32'(mul_a), 32'(m_a));
        chk("m_mul_b", 32'(mul_b), 32'(m_b));
      end
      exp_rv = m_out && (cyc >= m_hs + 11);
      chk("m_resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("m_resp_id", 32'(resp_id), 32'(m_id));
        chk("m_resp_data", 32'(resp_data), 32'(m_p));
      end
      // observed log
      seen = 0;
      for (int i = 0; i < N; i++) begin
        if (!seen && req_valid[i] && req_ready[i]) begin
          seen = 1;
          hs_id_q.push_back(i);
          hs_cyc_q.push_back(cyc);
        end
      end
      if (resp_valid && resp_ready) begin
        rsp_cyc_q.push_back(cyc);
        rsp_id_q.push_back(int'(resp_id));
        rsp_dat_q.push_back(resp_data);
      end
      // model update
      if (exp_rv && resp_ready) m_out = 0;
      if (k >= 0) begin
        m_out = 1;
        m_hs  = cyc;
        m_id  = k;
        m_a   = req_a[8*k +: 8];
        m_b   = req_b[8*k +: 8];
        m_p   = smul(m_a, m_b);
        m_ptr = (k + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    hs_id_q.delete();
    hs_cyc_q.delete();
    rsp_cyc_q.delete();
    rsp_id_q.delete();
    rsp_dat_q.delete();
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", 32'(resp_data), 0);
    chk("rst_mul_start", 32'(mul_start), 0);
    chk("rst_mul_a", 32'(mul_a), 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input int id, input logic [7:0] a, input logic [7:0] b, output int hc);
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    req_valid[id] = 1'b1;
    hc = -1;
    for (int i = 0; i < 60 && hc < 0; i++) begin
      @(negedge clk);
      if (req_valid[id] && req_ready[id]) hc = cyc;
    end
    chk("handshake_seen", 32'(hc >= 0), 1);
    tick();
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_resp(output int rc, output logic [15:0] d, output int rid);
    rc = -1;
    d = '0;
    rid = -1;
    for (int i = 0; i < 60 && rc < 0; i++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        rc  = cyc;
        d   = resp_data;
        rid = int'(resp_id);
      end
    end
    chk("resp_seen", 32'(rc >= 0), 1);
    tick();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          hc, hc2, rc, rid;
    logic [15:0] d;
    logic [7:0]  ta[N];
    logic [7:0]  tb[N];
    int          order[5];
    int          t0;
    order = '{0, 1, 2, 3, 0};

    repeat (2) tick();
    do_reset();

    // Basic: 5*7 from requester 0, latency 11
    send(0, 8'd5, 8'd7, hc);
    @(negedge clk);
    chk("start_pulse", 32'(mul_start), 1);
    wait_resp(rc, d, rid);
    chk("lat_basic", 32'(rc - hc), 11);
    chk("data_5x7", 32'(d), 32'h0023);
    chk("id_5x7", 32'(rid), 0);

    // Signed products
    send(2, 8'hFD, 8'h04, hc);
    wait_resp(rc, d, rid);
    chk("data_m3x4", 32'(d), 32'hFFF4);
    chk("id_m3x4", 32'(rid), 2);
    send(1, 8'h80, 8'h80, hc);
    wait_resp(rc, d, rid);
    chk("data_m128sq", 32'(d), 32'h4000);
    chk("id_m128sq", 32'(rid), 1);

    // All four requesting: order 0,1,2,3,0 with 12-cycle spacing
    do_reset();
    for (int k = 0; k < N; k++) begin
      ta[k] = 8'(k * 17 + 3);
      tb[k] = 8'(8'hF0 + k);
      req_a[8*k +: 8] = ta[k];
      req_b[8*k +: 8] = tb[k];
    end
    clear_logs();
    req_valid = '1;
    for (int i = 0; i < 120 && hs_id_q.size() < 5; i++) @(negedge clk);
    tick();
    req_valid = '0;
    for (int i = 0; i < 80 && rsp_cyc_q.size() < 5; i++) @(negedge clk);
    chk("rr_hs_count", 32'(hs_id_q.size() >= 5), 1);
    chk("rr_rsp_count", 32'(rsp_cyc_q.size() >= 5), 1);
    if (hs_id_q.size() >= 5 && rsp_cyc_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("rr_grant_order", 32'(hs_id_q[i]), 32'(order[i]));
        chk("rr_resp_id", 32'(rsp_id_q[i]), 32'(order[i]));
        chk("rr_resp_data", 32'(rsp_dat_q[i]), 32'(smul(ta[order[i]], tb[order[i]])));
        if (i > 0) chk("rr_gap", 32'(rsp_cyc_q[i] - rsp_cyc_q[i-1]), 12);
      end
    end

    // Response stall: pointer now at 1, all requesting, consumer not ready
    tick();
    resp_ready = 1'b0;
    req_valid = '1;
    t0 = -1;
    for (int i = 0; i < 40 && t0 < 0; i++) begin
      @(negedge clk);
      if (resp_valid) t0 = cyc;
    end
    chk("stall_resp_seen", 32'(t0 >= 0), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid), 1);
      chk("stall_id", 32'(resp_id), 1);
      chk("stall_data", 32'(resp_data), 32'(smul(ta[1], tb[1])));
      chk("stall_no_grant", 32'(req_ready), 0);
    end
    tick();
    resp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", 32'(resp_valid && resp_ready), 1);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Reset mid-operation: stale run must not be granted over nor returned
    send(2, 8'h11, 8'h22, hc);
    while (cyc < hc + 5) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_resp_valid", 32'(resp_valid), 0);
    chk("midrst_mul_a", 32'(mul_a), 0);
    chk("midrst_mul_b", 32'(mul_b), 0);
    chk("midrst_resp_id", 32'(resp_id), 0);
    tick();
    rst = 1'b0;
    send(1, 8'h9C, 8'h05, hc2);
    chk("midrst_regrant", 32'(hc2 - hc), 10);
    wait_resp(rc, d, rid);
    chk("midrst_lat", 32'(rc - hc2), 11);
    chk("midrst_data", 32'(d), 32'hFE0C);
    chk("midrst_id", 32'(rid), 1);

    // Pointer at 3 with 4'b1001: grant 3 then 0; then idle
    do_reset();
    send(2, 8'd3, 8'd3, hc);
    wait_resp(rc, d, rid);
    chk("ptr_setup_data", 32'(d), 32'h0009);
    clear_logs();
    req_a[8*3 +: 8] = 8'h7F;
    req_b[8*3 +: 8] = 8'h7F;
    req_a[8*0 +: 8] = 8'hFF;
    req_b[8*0 +: 8] = 8'h01;
    req_valid = 4'b1001;
    for (int i = 0; i < 60 && hs_id_q.size() < 2; i++) @(negedge clk);
    tick();
    req_valid = '0;
    for (int i = 0; i < 40 && rsp_cyc_q.size() < 2; i++) @(negedge clk);
    chk("wrap_counts", 32'(hs_id_q.size() == 2 && rsp_cyc_q.size() == 2), 1);
    if (hs_id_q.size() == 2 && rsp_cyc_q.size() == 2) begin
      chk("wrap_first", 32'(hs_id_q[0]), 3);
      chk("wrap_second", 32'(hs_id_q[1]), 0);
      chk("wrap_data3", 32'(rsp_dat_q[0]), 32'h3F01);
      chk("wrap_data0", 32'(rsp_dat_q[1]), 32'hFFFF);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_no_start", 32'(mul_start), 0);
    end
    chk("idle_no_hs", 32'(hs_id_q.size()), 2);

    // Randomized traffic against the model
    tick();
    clear_logs();
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst = ($urandom_range(0, 399) == 0);
      for (int k = 0; k < N; k++) begin
        req_valid[k] = ($urandom_range(0, 9) < 4);
        req_a[8*k +: 8] = 8'($urandom);
        req_b[8*k +: 8] = 8'($urandom);
      end
      resp_ready = ($urandom_range(0, 9) < 7);
    end
    tick();
    rst = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
